// File: rtl/ctrl_filtro_iir.sv
// ctrl_filtro_iir: micro-sequencer for the two-section IIR datapath (MAC, state memory, output register).
// Optional macro CTRL_FILTRO_CONT_EN adds the cuenta completed-sequence counter.
module ctrl_filtro_iir #(
  parameter int LAT_MULT = 0,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             muestra_lista,
  input  logic             clr_ovr,
  output logic [SEL_W-1:0] sel,
  output logic             rst_acum,
  output logic             leer,
  output logic             leer_y,
  output logic             desp,
  output logic             ocupado,
  output logic             listo,
`ifdef CTRL_FILTRO_CONT_EN
  output logic [15:0]      cuenta,
`endif
  output logic             overrun
);
  typedef enum logic [2:0] {IDLE, CLR_A, MAC_A, ESCR_F, CLR_B, MAC_B, ESCR_Y, DESP} state_t;
  state_t r_state, w_next;
  logic [2:0] r_hold, r_term, w_hold, w_term;
  logic r_pend, r_ovr, w_pend, w_ovr, w_start, w_fin_term, w_mac;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_hold <= '0;
      r_term <= '0;
      r_pend <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      r_state <= w_next;
      r_hold <= w_hold;
      r_term <= w_term;
      r_pend <= w_pend;
      r_ovr <= w_ovr;
    end
  end
  assign w_mac = (r_state == MAC_A) || (r_state == MAC_B);
  assign w_fin_term = r_hold == 3'(LAT_MULT);
  assign w_start = (r_state == IDLE) && (muestra_lista || r_pend);
  // A strobe landing in the same IDLE cycle as a pending start stays queued.
  assign w_pend = ocupado ? (r_pend | muestra_lista) : (w_start ? (muestra_lista & r_pend) : r_pend);
  assign w_ovr = (ocupado & muestra_lista & r_pend) | (r_ovr & ~clr_ovr);
  always_comb begin
    w_next = r_state;
    w_hold = r_hold;
    w_term = r_term;
    case (r_state)
      IDLE:   w_next = w_start ? CLR_A : IDLE;
      CLR_A:  begin
        w_next = MAC_A;
        w_hold = '0;
        w_term = 3'd0;
      end
      MAC_A, MAC_B: begin
        w_hold = w_fin_term ? 3'd0 : r_hold + 3'd1;
        w_term = r_term + {2'b0, w_fin_term};
        if (w_fin_term && r_term == ((r_state == MAC_A) ? 3'd2 : 3'd5))
          w_next = (r_state == MAC_A) ? ESCR_F : ESCR_Y;
      end
      ESCR_F: w_next = CLR_B;
      CLR_B:  begin
        w_next = MAC_B;
        w_hold = '0;
        w_term = 3'd3;
      end
      ESCR_Y: w_next = DESP;
      DESP:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  assign ocupado = r_state != IDLE;
  assign rst_acum = (r_state == CLR_A) || (r_state == CLR_B);
  assign sel = w_mac ? SEL_W'(r_term) : '0;
  assign leer = r_state == ESCR_F;
  assign leer_y = r_state == ESCR_Y;
  assign desp = r_state == DESP;
  assign listo = r_state == DESP;
  assign overrun = r_ovr;
`ifdef CTRL_FILTRO_CONT_EN
  logic [15:0] r_cuenta;
  always_ff @(posedge clk) begin
    if (rst) r_cuenta <= '0;
    else if (r_state == DESP) r_cuenta <= r_cuenta + 16'd1;
  end
  assign cuenta = r_cuenta;
`endif
endmodule

// File: tb/tb_ctrl_filtro_iir.sv
// tb_ctrl_filtro_iir: random and directed checks of two sequencer instances (LAT_MULT 0 and 2)
// against a cycle-offset reference model.
module tb_ctrl_filtro_iir;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic muestra_lista = 1'b0;
  logic clr_ovr = 1'b0;
  logic [3:0] sel0, sel1;
  logic ra0, le0, ly0, de0, oc0, li0, ov0;
  logic ra1, le1, ly1, de1, oc1, li1, ov1;
  logic [15:0] cu [2];
  logic [10:0] g [2];
  int n_chk = 0;
  int n_err = 0;
  int hh [2] = '{1, 3};
  int mk [2];
  bit mp [2];
  bit mo [2];
  logic [15:0] mc [2];
  always #5 clk = ~clk;
  ctrl_filtro_iir #(.LAT_MULT(0), .SEL_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .muestra_lista(muestra_lista), .clr_ovr(clr_ovr),
    .sel(sel0), .rst_acum(ra0), .leer(le0), .leer_y(ly0), .desp(de0),
    .ocupado(oc0), .listo(li0),
`ifdef CTRL_FILTRO_CONT_EN
    .cuenta(cu[0]),
`endif
    .overrun(ov0)
  );
  ctrl_filtro_iir #(.LAT_MULT(2), .SEL_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .muestra_lista(muestra_lista), .clr_ovr(clr_ovr),
    .sel(sel1), .rst_acum(ra1), .leer(le1), .leer_y(ly1), .desp(de1),
    .ocupado(oc1), .listo(li1),
`ifdef CTRL_FILTRO_CONT_EN
    .cuenta(cu[1]),
`endif
    .overrun(ov1)
  );
  assign g[0] = {sel0, ra0, le0, ly0, de0, oc0, li0, ov0};
  assign g[1] = {sel1, ra1, le1, ly1, de1, oc1, li1, ov1};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // k is the cycle offset inside a sequence (0 = idle, 1..5+6h busy), h cycles per term.
  function automatic logic [10:0] expv(input int k, input int h, input bit o);
    logic [3:0] s;
    int l;
    l = 5 + 6 * h;
    s = 4'd0;
    if (k >= 2 && k <= 1 + 3 * h) s = 4'((k - 2) / h);
    if (k >= 4 + 3 * h && k <= 3 + 6 * h) s = 4'(3 + (k - 4 - 3 * h) / h);
    return {s, k == 1 || k == 3 + 3 * h, k == 2 + 3 * h, k == 4 + 6 * h, k == l, k != 0, k == l, o};
  endfunction
  task automatic upd(input int i, input bit s, input bit c, input bit r);
    if (r) begin
      mk[i] = 0;
      mp[i] = 0;
      mo[i] = 0;
      mc[i] = 16'd0;
    end else if (mk[i] == 0) begin
      if (s || mp[i]) begin
        mk[i] = 1;
        mp[i] = s && mp[i];
      end
      mo[i] = mo[i] && !c;
    end else begin
      mo[i] = (s && mp[i]) || (mo[i] && !c);
      if (s) mp[i] = 1;
      if (mk[i] == 5 + 6 * hh[i]) begin
        mk[i] = 0;
        mc[i] = mc[i] + 16'd1;
      end else mk[i]++;
    end
  endtask
  task automatic step(input bit s, input bit c, input bit r);
    muestra_lista = s;
    clr_ovr = c;
    rst = r;
    @(posedge clk);
    for (int i = 0; i < 2; i++) upd(i, s, c, r);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("lat%0d_outs", hh[i] - 1), 32'(g[i]), 32'(expv(mk[i], hh[i], mo[i])));
`ifdef CTRL_FILTRO_CONT_EN
      chk($sformatf("lat%0d_cuenta", hh[i] - 1), 32'(cu[i]), 32'(mc[i]));
`endif
    end
  endtask
  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(0, 0, 0);
  endtask
  initial begin
    step(0, 0, 1);
    step(0, 0, 1);
    idle(20);
    step(1, 0, 0);
    idle(30);
    step(1, 0, 0);
    idle(3);
    step(1, 0, 0);
    idle(50);
    step(1, 0, 0);
    idle(3);
    step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    idle(50);
    step(0, 1, 0);
    idle(3);
    step(1, 0, 0);
    idle(5);
    step(0, 0, 1);
    idle(30);
    for (int j = 0; j < 3000; j++)
      step($urandom % 6 == 0, $urandom % 25 == 0, $urandom % 300 == 0);
    idle(40);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ctrl_filtro_iir.md
Name: ctrl_filtro_iir

Overview:
Sequencer for the two-section recursive filter datapath (constant mux, input mux, MAC/accumulator, rounding, 3-tap state memory, output register).
- On each input-sample strobe it runs a fixed 11-cycle micro-program (at LAT_MULT=0):
  - clear accumulator;
  - MAC terms sel 0..2;
  - write the rounded state value into memory;
  - clear accumulator;
  - MAC terms sel 3..5;
  - latch y;
  - shift the memory.
- It sits between the ADC/sample-rate logic and the filter datapath.
- It owns every datapath control line: sel, rst_acum, leer, leer_y, desp.

Parameters:
- LAT_MULT, 0: extra hold cycles per MAC term, for a pipelined multiplier. Range 0..7.
- SEL_W, 4: width of the sel output.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- muestra_lista  in  1  one-cycle strobe: a new sample is valid on uu.
- clr_ovr  in  1  clears the sticky overrun flag.
- sel  out  SEL_W  MAC term / constant select.
- rst_acum  out  1  accumulator clear.
- leer  out  1  write rounded value into state memory.
- leer_y  out  1  load output register y.
- desp  out  1  shift state memory (f->f1->f2).
- ocupado  out  1  high while a sequence runs.
- listo  out  1  one-cycle pulse, sequence complete.
- overrun  out  1  sticky: a sample strobe was dropped.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE.
  - All outputs 0, including sel=0.
  - pendiente=0, overrun=0, hold counter=0.
  - Reset mid-sequence aborts immediately; no partial leer/desp is issued afterwards.
- States and outputs (all registered-state Moore outputs; other outputs 0 unless listed):
  - IDLE: no outputs asserted.
  - CLR_A: rst_acum=1.
  - MAC_A: sel = term index 0,1,2.
  - ESCR_F: leer=1.
  - CLR_B: rst_acum=1.
  - MAC_B: sel = term index 3,4,5.
  - ESCR_Y: leer_y=1.
  - DESP: desp=1, listo=1.
- Term sequencing:
  - MAC_A/MAC_B hold each term for 1+LAT_MULT cycles, using a 3-bit hold counter and a 3-bit term counter.
  - The term counter advances when hold = LAT_MULT.
  - Leave MAC_A after term 2, and MAC_B after term 5.
- Transitions:
  - IDLE -> CLR_A when muestra_lista or pendiente.
  - CLR_A -> MAC_A -> ESCR_F -> CLR_B -> MAC_B -> ESCR_Y -> DESP -> IDLE.
  - The FSM always passes through IDLE for one cycle between sequences.
- ocupado = (state != IDLE).
- Busy length = 5 + 6*(1+LAT_MULT) cycles; 11 at LAT_MULT=0.
- Sample queue (one-deep):
  - Strobe while ocupado and pendiente=0: set pendiente=1.
  - Strobe while ocupado and pendiente=1: drop it and set overrun=1.
  - In IDLE with pendiente=1 and a strobe in the same cycle: start; pendiente stays 1.
  - In IDLE otherwise: start clears pendiente.
- overrun:
  - Cleared by clr_ovr.
  - If clr_ovr and a new overrun event coincide, the overrun set wins.
- Datapath timing: the accumulator result of the last term is valid during ESCR_F / ESCR_Y, so it is written at that cycle's closing edge.

Optional Feature:
- Macro: CTRL_FILTRO_CONT_EN.
- When defined:
  - Adds output cuenta[15:0], the count of completed sequences.
  - cuenta increments on the edge closing DESP and wraps 16'hFFFF -> 0.
  - cuenta resets to 0 on rst.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> all outputs 0, sel=0, ocupado=0; no activity with muestra_lista=0 for 20 cycles.
- Single sample, LAT_MULT=0: strobe at cycle t ->
  - rst_acum at t+1;
  - sel=0,1,2 at t+2..t+4;
  - leer at t+5;
  - rst_acum at t+6;
  - sel=3,4,5 at t+7..t+9;
  - leer_y at t+10;
  - desp and listo at t+11;
  - ocupado high for t+1..t+11.
- LAT_MULT=2: one strobe -> each sel value held 3 cycles; ocupado high 23 cycles; exactly one leer, one leer_y, one desp.
- Queueing:
  - Strobes at t and t+4 -> second sequence starts CLR_A at t+13; overrun stays 0.
  - Strobes at t, t+4, t+6 -> overrun=1 and only two sequences run.
  - clr_ovr then clears it.
- Reset mid-sequence: rst at t+6 -> next cycle IDLE, all outputs 0, no desp/leer_y pulse, pendiente cleared.
- CTRL_FILTRO_CONT_EN: run 3 sequences -> cuenta=3; preload/force 16'hFFFF, run 1 -> cuenta=0.
